// File: rtl/seleccion_pkg.sv
// Shared types and helpers for the current-setpoint selector.
// BCD converter state encoding and counter-width sizing.
package seleccion_pkg;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_LOAD,
    BCD_SHIFT,
    BCD_DONE
  } bcd_st_e;

  // Bits needed to count 0 .. n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Largest value representable in n BCD digits.
  function automatic logic [63:0] max_dec(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/seleccion_corriente_param_if.sv
// Button/setpoint bundle between a controller and the selector.
// master drives buttons and enable; slave returns setpoint, BCD, listo.
interface seleccion_corriente_param_if #(
  parameter int WIDTH = 7,
  parameter int N_DIG = 3
);
  logic [1:0]         botones;
  logic               ENi;
  logic [WIDTH-1:0]   I;
  logic [4*N_DIG-1:0] I_deco;
  logic               listo;

  modport master (
    output botones, ENi,
    input  I, I_deco, listo
  );

  modport slave (
    input  botones, ENi,
    output I, I_deco, listo
  );
endinterface

// File: rtl/antirrebote.sv
// Debouncer: 2-flop synchroniser plus stable-sample counter.
// Ports: clk, rst (sync, active-low), btn_i raw, deb_o debounced.
module antirrebote
  import seleccion_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic deb_o
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          deb_q;
  logic [CW-1:0] cnt_q;

  // Counter runs only while the synchronised level disagrees with
  // the accepted one; any agreeing sample restarts the window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      if (s2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        deb_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/seleccion_corriente_param.sv
// Current setpoint selector: debounced up/down buttons with repeat,
// bounded setpoint I and sequential BCD conversion to I_deco/listo.
module seleccion_corriente_param
  import seleccion_pkg::*;
#(
  parameter int WIDTH      = 7,
  parameter int I_MIN      = 0,
  parameter int I_MAX      = 100,
  parameter int I_INIT     = 0,
  parameter int STEP       = 1,
  parameter int DEB_CYCLES = 1000000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_RATE   = 10000000,
  parameter int N_DIG      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         botones,
  input  logic               ENi,
  output logic [WIDTH-1:0]   I,
  output logic [4*N_DIG-1:0] I_deco,
  output logic               listo
);

  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RCW  = cnt_w(RMAX);
  localparam logic [RCW-1:0] DLY_LAST  = RCW'(REP_DELAY - 1);
  localparam logic [RCW-1:0] RATE_LAST = RCW'(REP_RATE - 1);

  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MIN_W  = (WIDTH+1)'(I_MIN);
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(I_MAX);
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(I_MIN);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(I_MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(I_INIT);

  localparam int BW  = 4 * N_DIG;
  localparam int SW  = BW + WIDTH;
  localparam int SHW = cnt_w(WIDTH);
  localparam logic [SHW-1:0] SH_LAST = SHW'(WIDTH - 1);
  localparam logic [63:0]    DEC_MAX = max_dec(N_DIG);
  localparam logic [BW-1:0]  ALL9    = {N_DIG{4'h9}};

  // ---------------- buttons ----------------
  logic [1:0] deb;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clk   (clk),
    .rst   (rst),
    .btn_i (botones[0]),
    .deb_o (deb[0])
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (clk),
    .rst   (rst),
    .btn_i (botones[1]),
    .deb_o (deb[1])
  );

  logic [1:0]          prev_q;
  logic [1:0]          inh_q, inh_d;
  logic [1:0]          rate_q, rate_d;
  logic [1:0][RCW-1:0] rcnt_q, rcnt_d;
  logic [1:0]          rise, hold, fire, ok, ev;
  logic                both;

  // inh marks a button that took part in a both-pressed conflict;
  // it stays silent until released and pressed again.
  always_comb begin
    both   = &deb;
    rise   = '0;
    hold   = '0;
    fire   = '0;
    ok     = '0;
    ev     = '0;
    inh_d  = '0;
    rcnt_d = rcnt_q;
    rate_d = rate_q;
    for (int b = 0; b < 2; b++) begin
      rise[b]  = deb[b] & ~prev_q[b];
      hold[b]  = deb[b] & prev_q[b];
      fire[b]  = hold[b] &&
                 (rcnt_q[b] == (rate_q[b] ? RATE_LAST : DLY_LAST));
      inh_d[b] = deb[b] & (inh_q[b] | both);
      ok[b]    = ENi & ~both & ~inh_q[b];
      ev[b]    = ok[b] & (rise[b] | fire[b]);
      if (!ok[b] || !deb[b] || rise[b]) begin
        rcnt_d[b] = '0;
        rate_d[b] = 1'b0;
      end else if (fire[b]) begin
        rcnt_d[b] = '0;
        rate_d[b] = 1'b1;
      end else begin
        rcnt_d[b] = rcnt_q[b] + 1'b1;
      end
    end
  end

  // ---------------- setpoint ----------------
  logic [WIDTH-1:0] i_q, i_d;
  logic [WIDTH:0]   i_w, up_w, dn_w;

  always_comb begin
    i_w  = {1'b0, i_q};
    up_w = i_w + STEP_W;
    dn_w = i_w - STEP_W;
    i_d  = i_q;
    if (ev[1]) begin
      i_d = (up_w > MAX_W) ? MAX_V : up_w[WIDTH-1:0];
    end else if (ev[0]) begin
      i_d = (i_w < MIN_W + STEP_W) ? MIN_V : dn_w[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= '0;
      inh_q  <= '0;
      rate_q <= '0;
      rcnt_q <= '0;
      i_q    <= INIT_V;
    end else begin
      prev_q <= deb;
      inh_q  <= inh_d;
      rate_q <= rate_d;
      rcnt_q <= rcnt_d;
      i_q    <= i_d;
    end
  end

  // ---------------- BCD conversion ----------------
  bcd_st_e         st_q;
  logic [WIDTH:0]  last_q;
  logic [SW-1:0]   sr_q, sr_adj;
  logic [SHW-1:0]  sh_q;
  logic            sat_q;
  logic [BW-1:0]   deco_q;
  logic            listo_q;
  logic            over;

  // last_q MSB is set at reset so it can never match {0, I}; this
  // forces one conversion right after reset.
  assign over = {{(64-WIDTH){1'b0}}, last_q[WIDTH-1:0]} > DEC_MAX;

  always_comb begin
    sr_adj = sr_q;
    for (int d = 0; d < N_DIG; d++) begin
      if (sr_q[WIDTH+4*d +: 4] >= 4'd5)
        sr_adj[WIDTH+4*d +: 4] = sr_q[WIDTH+4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q    <= BCD_IDLE;
      last_q  <= {1'b1, {WIDTH{1'b0}}};
      sr_q    <= '0;
      sh_q    <= '0;
      sat_q   <= 1'b0;
      deco_q  <= '0;
      listo_q <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      unique case (st_q)
        BCD_IDLE: begin
          if ({1'b0, i_q} != last_q) begin
            last_q <= {1'b0, i_q};
            st_q   <= BCD_LOAD;
          end
        end
        BCD_LOAD: begin
          sr_q  <= {{BW{1'b0}}, last_q[WIDTH-1:0]};
          sat_q <= over;
          sh_q  <= '0;
          st_q  <= BCD_SHIFT;
        end
        BCD_SHIFT: begin
          sr_q <= sr_adj << 1;
          sh_q <= sh_q + 1'b1;
          if (sh_q == SH_LAST) st_q <= BCD_DONE;
        end
        BCD_DONE: begin
          deco_q  <= sat_q ? ALL9 : sr_q[SW-1 -: BW];
          listo_q <= 1'b1;
          st_q    <= BCD_IDLE;
        end
      endcase
    end
  end

  assign I      = i_q;
  assign I_deco = deco_q;
  assign listo  = listo_q;

endmodule
